// File: rtl/vec_op_engine.sv
// Vector ALU sweep engine: reads operand pairs at addresses 0..N-1, applies the
// latched op and streams results out with a write strobe, a done pulse and sticky overflow.
module vec_op_engine #(
    parameter int unsigned MEM_WIDTH = 32,
    parameter int unsigned MEM_DEPTH = 8,
    localparam int unsigned ADDR_W = $clog2(MEM_DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [2:0]           mode_i,
    input  logic [ADDR_W:0]      len_i,
    output logic                 rd_en_o,
    output logic [ADDR_W-1:0]    rd_addr_o,
    input  logic [MEM_WIDTH-1:0] operand1_i,
    input  logic [MEM_WIDTH-1:0] operand2_i,
    output logic                 wr_en_o,
    output logic [ADDR_W-1:0]    wr_addr_o,
    output logic [MEM_WIDTH-1:0] result_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 overflow_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    localparam logic [ADDR_W:0] DepthN = (ADDR_W + 1)'(MEM_DEPTH);

    state_e              state_q;
    logic [2:0]          mode_q;
    logic [ADDR_W:0]     n_q;
    logic                v1_q;
    logic [ADDR_W-1:0]   a1_q;

    logic [ADDR_W:0]        len_eff;
    logic                   last_addr;
    logic [MEM_WIDTH-1:0]   sum;
    logic [MEM_WIDTH-1:0]   diff;
    logic [2*MEM_WIDTH-1:0] prod;
    logic [MEM_WIDTH-1:0]   alu_res;
    logic                   alu_ovf;

    assign len_eff   = (len_i > DepthN) ? DepthN : len_i;
    assign last_addr = ({1'b0, rd_addr_o} == (n_q - 1'b1));

    // Operands arrive the cycle after the read strobe, so the ALU works straight
    // off the memory outputs and the result is registered with the write strobe.
    always_comb begin
        sum     = operand1_i + operand2_i;
        diff    = operand1_i - operand2_i;
        prod    = {{MEM_WIDTH{1'b0}}, operand1_i} * {{MEM_WIDTH{1'b0}}, operand2_i};
        alu_res = '0;
        alu_ovf = 1'b0;
        case (mode_q)
            3'd0: begin
                alu_res = sum;
                alu_ovf = (operand1_i[MEM_WIDTH-1] == operand2_i[MEM_WIDTH-1]) &&
                          (sum[MEM_WIDTH-1] != operand1_i[MEM_WIDTH-1]);
            end
            3'd1: begin
                alu_res = diff;
                alu_ovf = (operand1_i[MEM_WIDTH-1] != operand2_i[MEM_WIDTH-1]) &&
                          (diff[MEM_WIDTH-1] != operand1_i[MEM_WIDTH-1]);
            end
            3'd2: begin
                alu_res = prod[MEM_WIDTH-1:0];
                alu_ovf = |prod[2*MEM_WIDTH-1:MEM_WIDTH];
            end
            3'd3: alu_res = operand1_i & operand2_i;
            3'd4: alu_res = operand1_i | operand2_i;
            3'd5: alu_res = operand1_i ^ operand2_i;
            3'd6: alu_res = ($signed(operand1_i) > $signed(operand2_i)) ? operand1_i : operand2_i;
            default: alu_res = ($signed(operand1_i) < $signed(operand2_i)) ? operand1_i : operand2_i;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            mode_q     <= '0;
            n_q        <= '0;
            v1_q       <= 1'b0;
            a1_q       <= '0;
            rd_en_o    <= 1'b0;
            rd_addr_o  <= '0;
            wr_en_o    <= 1'b0;
            wr_addr_o  <= '0;
            result_o   <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            done_o  <= 1'b0;
            v1_q    <= rd_en_o;
            a1_q    <= rd_addr_o;
            wr_en_o <= v1_q;
            if (v1_q) begin
                result_o   <= alu_res;
                wr_addr_o  <= a1_q;
                overflow_o <= overflow_o | alu_ovf;
            end
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        mode_q     <= mode_i;
                        n_q        <= len_eff;
                        overflow_o <= 1'b0;
                        if (len_eff == '0) begin
                            done_o <= 1'b1;
                        end else begin
                            state_q   <= StRun;
                            busy_o    <= 1'b1;
                            rd_en_o   <= 1'b1;
                            rd_addr_o <= '0;
                        end
                    end
                end
                StRun: begin
                    if (last_addr) begin
                        rd_en_o <= 1'b0;
                        state_q <= StDrain;
                    end else begin
                        rd_addr_o <= rd_addr_o + 1'b1;
                    end
                end
                StDrain: begin
                    // Pipeline is empty once the final element has reached the write stage.
                    if (!v1_q) begin
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_op_engine.sv
// Scoreboard bench for vec_op_engine: stimulus queues expected writes, a negedge
// monitor pops and compares them against each DUT write strobe.
module tb_vec_op_engine;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    logic         start, start5;
    logic [2:0]   mode;
    logic [3:0]   len;

    logic         rd_en, wr_en, busy, done, ovf;
    logic [2:0]   rd_addr, wr_addr;
    logic [W-1:0] op1, op2, result;

    logic         rd_en5, wr_en5, busy5, done5, ovf5;
    logic [2:0]   rd_addr5, wr_addr5;
    logic [W-1:0] op1_5, op2_5, result5;

    logic [W-1:0] mem1 [8];
    logic [W-1:0] mem2 [8];

    vec_op_engine #(.MEM_WIDTH(W), .MEM_DEPTH(8)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_i(mode), .len_i(len),
        .rd_en_o(rd_en), .rd_addr_o(rd_addr), .operand1_i(op1), .operand2_i(op2),
        .wr_en_o(wr_en), .wr_addr_o(wr_addr), .result_o(result), .busy_o(busy),
        .done_o(done), .overflow_o(ovf)
    );

    vec_op_engine #(.MEM_WIDTH(W), .MEM_DEPTH(5)) u_dut5 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start5), .mode_i(mode), .len_i(len),
        .rd_en_o(rd_en5), .rd_addr_o(rd_addr5), .operand1_i(op1_5), .operand2_i(op2_5),
        .wr_en_o(wr_en5), .wr_addr_o(wr_addr5), .result_o(result5), .busy_o(busy5),
        .done_o(done5), .overflow_o(ovf5)
    );

    // Synchronous-read operand memories
    always @(posedge clk) begin
        if (rd_en) begin
            op1 <= mem1[rd_addr];
            op2 <= mem2[rd_addr];
        end
        if (rd_en5) begin
            op1_5 <= mem1[rd_addr5];
            op2_5 <= mem2[rd_addr5];
        end
    end

    typedef struct {
        logic [2:0]   addr;
        logic [W-1:0] data;
        logic         ovf;
        int           at;
    } wr_t;

    wr_t sb[$];
    wr_t sb5[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void push(input bit d5, input int a, input logic [W-1:0] d,
                                 input logic o, input int at);
        wr_t e;
        e.addr = 3'(a);
        e.data = d;
        e.ovf  = o;
        e.at   = at;
        if (d5) sb5.push_back(e);
        else    sb.push_back(e);
    endfunction

    always @(negedge clk) begin
        wr_t e;
        if (wr_en) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=addr %0d data %0h required=no write",
                         wr_addr, result);
            end else begin
                e = sb.pop_front();
                check("wr_addr", wr_addr, e.addr);
                check("wr_data", result, e.data);
                check("wr_ovf", ovf, e.ovf);
                check("wr_cycle", cyc, e.at);
            end
        end
        if (wr_en5) begin
            if (sb5.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write5 actual=addr %0d data %0h required=no write",
                         wr_addr5, result5);
            end else begin
                e = sb5.pop_front();
                check("wr5_addr", wr_addr5, e.addr);
                check("wr5_data", result5, e.data);
                check("wr5_cycle", cyc, e.at);
            end
        end
    end

    task automatic start_pass(input logic [2:0] m, input logic [3:0] l, output int c0);
        @(negedge clk);
        mode  = m;
        len   = l;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c0    = cyc;
        // Scramble controls once latched; results must not change.
        mode  = ~m;
        len   = 4'd1;
    endtask

    task automatic wait_done(input int exp_cyc, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 40);
        check(name, done ? cyc : -1, exp_cyc);
        check({name, "_sb_empty"}, sb.size(), 0);
    endtask

    task automatic fill_add();
        for (int i = 0; i < 8; i++) begin
            mem1[i] = W'(i);
            mem2[i] = W'(2 * i);
        end
    endtask

    initial begin
        int c0;
        int n_done;
        int n_rd;
        start  = 1'b0;
        start5 = 1'b0;
        mode   = 3'd0;
        len    = 4'd0;
        for (int i = 0; i < 8; i++) begin
            mem1[i] = W'(i);
            mem2[i] = 32'd10;
        end

        #2 rst_n = 1'b0;
        #1;
        check("rst_ctrl", {29'd0, rd_en, wr_en, busy}, 0);
        check("rst_addr", {26'd0, rd_addr, wr_addr}, 0);
        check("rst_flags", {30'd0, done, ovf}, 0);
        check("rst_result", result, 0);
        check("rst5_outputs", {25'd0, rd_en5, wr_en5, busy5, done5, ovf5, wr_addr5[1:0]}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a pass
        start_pass(3'd0, 4'd8, c0);
        for (int i = 0; i < 4; i++) push(0, i, W'(10 + i), 1'b0, c0 + 2 + i);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_wr_en", wr_en, 0);
        check("rst_mid_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        n_rd   = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) n_done++;
            if (rd_en) n_rd++;
        end
        check("rst_mid_done", n_done, 0);
        check("rst_mid_rd", n_rd, 0);
        check("rst_mid_sb_empty", sb.size(), 0);

        // Full ADD pass
        fill_add();
        start_pass(3'd0, 4'd8, c0);
        for (int i = 0; i < 8; i++) push(0, i, W'(3 * i), 1'b0, c0 + 2 + i);
        wait_done(c0 + 10, "add_done");
        check("add_ovf", ovf, 0);

        // Overflow, stickiness, clear on next start
        mem1[3] = 32'h7FFF_FFFF;
        mem2[3] = 32'h0000_0001;
        start_pass(3'd0, 4'd8, c0);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) push(0, i, 32'h8000_0000, 1'b1, c0 + 2 + i);
            else        push(0, i, W'(3 * i), (i > 3), c0 + 2 + i);
        end
        wait_done(c0 + 10, "ovf_done");
        check("ovf_sticky", ovf, 1);
        start_pass(3'd4, 4'd3, c0);
        check("ovf_clear", ovf, 0);
        push(0, 0, 32'd0, 1'b0, c0 + 2);
        push(0, 1, 32'd3, 1'b0, c0 + 3);
        push(0, 2, 32'd6, 1'b0, c0 + 4);
        wait_done(c0 + 5, "or_len3_done");

        // Length edge cases
        fill_add();
        start_pass(3'd0, 4'd0, c0);
        check("len0_done", done, 1);
        check("len0_busy", busy, 0);
        check("len0_rd_en", rd_en, 0);
        @(negedge clk);
        check("len0_done_clear", done, 0);
        check("len0_busy_after", busy, 0);
        start_pass(3'd0, 4'd15, c0);
        for (int i = 0; i < 8; i++) push(0, i, W'(3 * i), 1'b0, c0 + 2 + i);
        wait_done(c0 + 10, "len15_done");

        // Signed and multiply modes on a single element
        mem1[0] = 32'hFFFF_FFFF;
        mem2[0] = 32'd5;
        start_pass(3'd6, 4'd1, c0);
        push(0, 0, 32'd5, 1'b0, c0 + 2);
        wait_done(c0 + 3, "max_done");
        start_pass(3'd7, 4'd1, c0);
        push(0, 0, 32'hFFFF_FFFF, 1'b0, c0 + 2);
        wait_done(c0 + 3, "min_done");
        start_pass(3'd1, 4'd1, c0);
        push(0, 0, 32'hFFFF_FFFA, 1'b0, c0 + 2);
        wait_done(c0 + 3, "sub_done");
        mem1[0] = 32'h0001_0000;
        mem2[0] = 32'h0001_0000;
        start_pass(3'd2, 4'd1, c0);
        push(0, 0, 32'd0, 1'b1, c0 + 2);
        wait_done(c0 + 3, "mul_done");
        check("mul_ovf", ovf, 1);

        // start_i held high: second pass follows done with a one-cycle gap
        fill_add();
        @(negedge clk);
        mode  = 3'd0;
        len   = 4'd4;
        start = 1'b1;
        @(negedge clk);
        c0 = cyc;
        for (int i = 0; i < 4; i++) push(0, i, W'(3 * i), 1'b0, c0 + 2 + i);
        for (int i = 0; i < 4; i++) push(0, i, W'(3 * i), 1'b0, c0 + 9 + i);
        repeat (6) @(negedge clk);
        check("held_done1", done, 1);
        check("held_gap_busy", busy, 0);
        @(negedge clk);
        check("held_restart_busy", busy, 1);
        start = 1'b0;
        wait_done(c0 + 13, "held_done2");

        // Non-power-of-two depth
        @(negedge clk);
        mode   = 3'd0;
        len    = 4'd5;
        start5 = 1'b1;
        @(negedge clk);
        start5 = 1'b0;
        c0     = cyc;
        mode   = 3'd3;
        len    = 4'd2;
        for (int i = 0; i < 5; i++) push(1, i, W'(3 * i), 1'b0, c0 + 2 + i);
        n_rd = 0;
        do begin
            @(negedge clk);
            n_rd++;
        end while (!done5 && n_rd < 40);
        check("d5_done", done5 ? cyc : -1, c0 + 7);
        check("d5_sb_empty", sb5.size(), 0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
